// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared constants and helpers for stream_demux
package stream_demux_pkg;

    localparam int CNT_W = 16;

    function automatic int sel_width(input int nch);
        return (nch > 2) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// rtl/demux_chan_reg.sv - one output channel holding register with valid bit
module demux_chan_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;

    // A load in the same cycle as a drain replaces the word and keeps valid set.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = d;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - 1-to-NCH registered stream demux; STREAM_DEMUX_CNT_EN adds per-channel transfer counters
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int W     = 8,
    parameter int NCH   = 4,
    parameter int SEL_W = sel_width(NCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [W-1:0]       d,
    input  logic [SEL_W-1:0]   s,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [NCH*W-1:0]   y,
    output logic [NCH-1:0]     y_valid,
    input  logic [NCH-1:0]     y_ready,
    output logic               sel_err,
`ifdef STREAM_DEMUX_CNT_EN
    input  logic [SEL_W-1:0]   cnt_sel,
    output logic [CNT_W-1:0]   cnt,
`endif
    input  logic               err_clr
);

    logic [NCH-1:0] sel_hot;
    logic [NCH-1:0] chan_ready;
    logic [NCH-1:0] load;
    logic           sel_ok;
    logic           sel_err_q, sel_err_d;

    // Decoding against each legal index keeps out-of-range selects all-zero.
    always_comb begin
        sel_hot = '0;
        for (int k = 0; k < NCH; k++) begin
            if (s == SEL_W'(k)) sel_hot[k] = 1'b1;
        end
    end

    assign sel_ok     = |sel_hot;
    assign chan_ready = ~y_valid | y_ready;
    assign in_ready   = !sel_ok || |(sel_hot & chan_ready);
    assign load       = (in_valid && in_ready) ? sel_hot : '0;

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_chan
            demux_chan_reg #(.W(W)) u_chan (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (load[g]),
                .d     (d),
                .ready (y_ready[g]),
                .data  (y[g*W +: W]),
                .valid (y_valid[g])
            );
        end
    endgenerate

    always_comb begin
        sel_err_d = sel_err_q;
        if (in_valid && !sel_ok) sel_err_d = 1'b1;
        else if (err_clr)        sel_err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sel_err_q <= 1'b0;
        else        sel_err_q <= sel_err_d;
    end

    assign sel_err = sel_err_q;

`ifdef STREAM_DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [CNT_W-1:0] cnt_mux;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            cnt_d[k] = cnt_q[k];
            if (err_clr)                      cnt_d[k] = '0;
            else if (y_valid[k] && y_ready[k]) cnt_d[k] = cnt_q[k] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    always_comb begin
        cnt_mux = '0;
        for (int k = 0; k < NCH; k++) begin
            if (cnt_sel == SEL_W'(k)) cnt_mux = cnt_q[k];
        end
    end

    assign cnt = cnt_mux;
`endif

endmodule
